// File: rtl/serial_seq_pkg.sv
// Shared types and defaults for the serial sequence controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam int PW_DEF = 8;
    localparam int CW_DEF = 4;

    // Out-of-range lengths (zero, or wider than the pattern) fall back to a full-width run.
    function automatic int eff_len(input logic [3:0] len, input int pw);
        if (len == 4'd0 || int'(len) > pw) begin
            return pw;
        end
        return int'(len);
    endfunction

endpackage

// File: rtl/serial_seq_ctrl_if.sv
// Bundle of run-request, serial-bit and status signals between driver and controller.
// Latency: n/a (wiring only).
// Backpressure: none; start is simply ignored while a run is in progress.
interface serial_seq_ctrl_if #(
    parameter int PW = serial_seq_pkg::PW_DEF,
    parameter int CW = serial_seq_pkg::CW_DEF
);
    logic          start;
    logic [PW-1:0] pattern;
    logic [3:0]    len;
    logic          z;
    logic          x;
    logic          x_valid;
    logic          det_clr;
    logic          busy;
    logic          done;
    logic [CW-1:0] hit_cnt;

    modport master (
        output start, pattern, len, z,
        input  x, x_valid, det_clr, busy, done, hit_cnt
    );

    modport slave (
        input  start, pattern, len, z,
        output x, x_valid, det_clr, busy, done, hit_cnt
    );
endinterface

// File: rtl/serial_seq_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Latency: q updates on the rising edge after clr/inc.
// Backpressure: none; holds at all-ones once saturated.
module sat_counter #(
    parameter int CW = serial_seq_pkg::CW_DEF
) (
    input  logic          cp,
    input  logic          rd,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] q
);

    // Count up on inc, stick at the maximum value, clear on request.
    always_ff @(posedge cp or negedge rd) begin
        if (!rd) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {CW{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/serial_seq_ctrl.sv
// Serialises a latched pattern MSB-first into a detector and counts its hits.
// Latency: start at edge N -> LOAD N+1 -> first bit N+2 -> done N+2+L.
// Backpressure: start is ignored outside IDLE; no stalling once a run begins.
module serial_seq_ctrl
    import serial_seq_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic             cp,
    input  logic             rd,
    serial_seq_ctrl_if.slave bus
);

    localparam int BW = $clog2(PW + 1);

    state_t        state;
    state_t        state_nx;
    logic [PW-1:0] sr;
    logic [BW-1:0] bit_cnt;
    logic          accept;
    logic          last_bit;
    logic          hit_inc;
    logic [CW-1:0] hit_q;

    assign accept   = (state == IDLE) && bus.start;
    assign last_bit = (bit_cnt == BW'(1));
    assign hit_inc  = (state == SHIFT) && bus.z;

    // State register; reset abandons any run in flight.
    always_ff @(posedge cp or negedge rd) begin
        if (!rd) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: one LOAD cycle, L SHIFT cycles, one DONE cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = LOAD;
            LOAD:    state_nx = SHIFT;
            SHIFT:   if (last_bit) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Shift register and remaining-bit count: load on accept, consume one bit per SHIFT edge.
    always_ff @(posedge cp or negedge rd) begin
        if (!rd) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (accept) begin
            sr      <= bus.pattern;
            bit_cnt <= BW'(eff_len(bus.len, PW));
        end else if (state == SHIFT) begin
            sr      <= {sr[PW-2:0], 1'b0};
            bit_cnt <= bit_cnt - 1'b1;
        end
    end

    // Outputs decode straight from state so reset forces them low without waiting for a clock.
    always_comb begin
        bus.x       = 1'b0;
        bus.x_valid = 1'b0;
        bus.det_clr = 1'b0;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        case (state)
            LOAD: begin
                bus.det_clr = 1'b1;
                bus.busy    = 1'b1;
            end
            SHIFT: begin
                bus.x       = sr[PW-1];
                bus.x_valid = 1'b1;
                bus.busy    = 1'b1;
            end
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    sat_counter #(.CW(CW)) u_hits (
        .cp  (cp),
        .rd  (rd),
        .clr (accept),
        .inc (hit_inc),
        .q   (hit_q)
    );

    assign bus.hit_cnt = hit_q;

endmodule

// File: tb/tb_serial_seq_ctrl.sv
// Directed bench: two controllers (CW=4 and CW=2) driven by identical stimulus.
// Latency: checks sampled 1 time unit after each rising cp edge.
// Backpressure: start held high across a run to confirm it is ignored.
module tb_serial_seq_ctrl;

    logic cp;
    logic rd;
    int   errors = 0;
    int   checks = 0;

    serial_seq_ctrl_if #(.PW(8), .CW(4)) b1 ();
    serial_seq_ctrl_if #(.PW(8), .CW(2)) b2 ();

    assign b2.start   = b1.start;
    assign b2.pattern = b1.pattern;
    assign b2.len     = b1.len;
    assign b2.z       = b1.z;

    serial_seq_ctrl #(.PW(8), .CW(4)) dut  (.cp(cp), .rd(rd), .bus(b1));
    serial_seq_ctrl #(.PW(8), .CW(2)) dut2 (.cp(cp), .rd(rd), .bus(b2));

    initial cp = 1'b0;
    always #5 cp = ~cp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge cp);
        #1;
    endtask

    // One complete run from IDLE; L is the effective length, hits the CW=4 expectation.
    task automatic run(input logic [7:0] pat, input logic [3:0] ln, input logic zv,
                       input int L, input int hits);
        int hits2;
        hits2 = (hits > 3) ? 3 : hits;
        b1.start   = 1'b1;
        b1.pattern = pat;
        b1.len     = ln;
        b1.z       = zv;
        tick();
        b1.start = 1'b0;
        chk("load_det_clr", b1.det_clr, 1);
        chk("load_busy", b1.busy, 1);
        chk("load_x_valid", b1.x_valid, 0);
        chk("load_x", b1.x, 0);
        chk("load_hit_clr", b1.hit_cnt, 0);
        chk("load_hit_clr2", b2.hit_cnt, 0);
        for (int i = 0; i < L; i++) begin
            tick();
            chk("shift_x_valid", b1.x_valid, 1);
            chk("shift_x", b1.x, pat[7-i]);
            chk("shift_det_clr", b1.det_clr, 0);
            chk("shift_busy", b1.busy, 1);
            chk("shift_done", b1.done, 0);
        end
        tick();
        chk("done_pulse", b1.done, 1);
        chk("done_busy", b1.busy, 0);
        chk("done_x_valid", b1.x_valid, 0);
        chk("done_x", b1.x, 0);
        chk("done_hits", b1.hit_cnt, hits);
        chk("done_hits_sat", b2.hit_cnt, hits2);
        chk("done_pulse2", b2.done, 1);
        tick();
        chk("idle_done_low", b1.done, 0);
        chk("idle_busy", b1.busy, 0);
        chk("idle_hits_hold", b1.hit_cnt, hits);
        chk("idle_hits_hold2", b2.hit_cnt, hits2);
    endtask

    initial begin
        rd         = 1'b0;
        b1.start   = 1'b0;
        b1.pattern = 8'h00;
        b1.len     = 4'd0;
        b1.z       = 1'b0;
        #12;
        chk("rst_busy", b1.busy, 0);
        chk("rst_done", b1.done, 0);
        chk("rst_x_valid", b1.x_valid, 0);
        chk("rst_det_clr", b1.det_clr, 0);
        chk("rst_hits", b1.hit_cnt, 0);
        rd = 1'b1;
        tick();
        chk("idle_after_rst", b1.busy, 0);

        // Full-width pattern, detector never fires.
        run(8'b1011_0100, 4'd8, 1'b0, 8, 0);
        // Short run with z tied high: LOAD/DONE cycles must not count.
        run(8'hFF, 4'd3, 1'b1, 3, 3);
        // len=0 falls back to full width; CW=2 instance saturates at 3.
        run(8'hFF, 4'd0, 1'b1, 8, 8);
        // len above PW also falls back to full width.
        run(8'h5A, 4'd12, 1'b0, 8, 0);

        // Reset in the middle of a run.
        b1.start   = 1'b1;
        b1.pattern = 8'hC3;
        b1.len     = 4'd8;
        b1.z       = 1'b1;
        tick();
        b1.start = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_third_bit", b1.x_valid, 1);
        chk("mid_hits_before_rst", b1.hit_cnt, 2);
        #3;
        rd = 1'b0;
        #1;
        chk("arst_busy", b1.busy, 0);
        chk("arst_x_valid", b1.x_valid, 0);
        chk("arst_x", b1.x, 0);
        chk("arst_det_clr", b1.det_clr, 0);
        chk("arst_done", b1.done, 0);
        chk("arst_hits", b1.hit_cnt, 0);
        tick();
        chk("arst_hold_done", b1.done, 0);
        #3;
        rd = 1'b1;
        tick();
        chk("post_rst_no_done", b1.done, 0);
        chk("post_rst_idle", b1.busy, 0);
        run(8'hC3, 4'd8, 1'b1, 8, 8);

        // start held high for the whole run: no restart until IDLE after DONE.
        b1.start   = 1'b1;
        b1.pattern = 8'hA0;
        b1.len     = 4'd3;
        b1.z       = 1'b0;
        tick();
        chk("hold_load", b1.det_clr, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_shift_valid", b1.x_valid, 1);
            chk("hold_shift_no_clr", b1.det_clr, 0);
        end
        tick();
        chk("hold_done", b1.done, 1);
        tick();
        chk("hold_idle_busy", b1.busy, 0);
        chk("hold_idle_det_clr", b1.det_clr, 0);
        tick();
        chk("hold_restart_clr", b1.det_clr, 1);
        b1.start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("hold_final_idle", b1.busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_seq_ctrl.md
SERIAL_SEQ_CTRL -- requirements
Module: serial_seq_ctrl

Interface
REQ-001 SHALL provide parameter PW, default 8, pattern register width in bits.
REQ-002 SHALL provide parameter CW, default 4, hit counter width in bits.
REQ-003 SHALL have port cp  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port rd  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  request to begin a serial run, sampled on rising cp.
REQ-006 SHALL have port pattern  input  PW  bit pattern to serialise, MSB first.
REQ-007 SHALL have port len  input  4  number of bits to send.
REQ-008 SHALL have port z  input  1  detector Mealy output for the currently presented bit.
REQ-009 SHALL have port x  output  1  serial bit driven to the detector.
REQ-010 SHALL have port x_valid  output  1  x carries a pattern bit this cycle.
REQ-011 SHALL have port det_clr  output  1  one-cycle synchronous clear request to the detector.
REQ-012 SHALL have port busy  output  1  run in progress (LOAD or SHIFT).
REQ-013 SHALL have port done  output  1  one-cycle run-complete pulse.
REQ-014 SHALL have port hit_cnt  output  CW  number of cycles with z=1 during the last run.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, SHIFT, DONE.
REQ-016 IDLE: start=1 at a rising edge SHALL latch pattern into the shift register, latch effective length, clear hit_cnt, and enter LOAD.
REQ-017 Effective length SHALL be len when 1 <= len <= PW; len=0 or len>PW SHALL be treated as PW.
REQ-018 LOAD SHALL last exactly one cycle with det_clr=1, x_valid=0, and then enter SHIFT.
REQ-019 SHIFT: x SHALL equal shift-register MSB, x_valid=1; each rising edge SHALL shift left by one, filling with 0, and decrement the bit count.
REQ-020 SHIFT: z=1 at a rising edge SHALL increment hit_cnt, saturating at 2^CW-1; z SHALL be ignored in every other state.
REQ-021 SHIFT SHALL enter DONE on the edge that consumes the last bit; the run SHALL occupy exactly effective-length SHIFT cycles.
REQ-022 DONE SHALL last one cycle with done=1, busy=0, x_valid=0, then return to IDLE.
REQ-023 start SHALL be ignored in LOAD, SHIFT and DONE; start in IDLE the cycle after DONE SHALL begin a new run.
REQ-024 hit_cnt SHALL hold its value from DONE until the next accepted start.
REQ-025 busy SHALL be 1 exactly in LOAD and SHIFT; x SHALL be 0 whenever x_valid=0.
REQ-026 Latency: start accepted at edge N -> LOAD in cycle N+1 -> first bit in N+2 -> done in N+2+L for effective length L.

Reset
REQ-027 rd=0 SHALL immediately force state IDLE, x=0, x_valid=0, det_clr=0, busy=0, done=0, hit_cnt=0, and clear the shift register and bit count, regardless of cp.
REQ-028 Reset asserted mid-run SHALL abandon the run with no done pulse; first start after rd=1 SHALL be handled as from IDLE.

Structure
REQ-029 State encoding (IDLE=2'b00, LOAD=2'b01, SHIFT=2'b10, DONE=2'b11) and PW/CW defaults SHALL live in shared package serial_seq_pkg.
REQ-030 The saturating hit counter SHALL be a sub-module sat_counter (parameter CW; ports cp, rd, clr, inc, q).

Verification
REQ-031 pattern=8'b1011_0100, len=8, z=0 -> x sequence 1,0,1,1,0,1,0,0 on cycles N+2..N+9, done at N+10, hit_cnt=0.
REQ-032 pattern=8'hFF, len=3, z tied 1 -> three SHIFT cycles, done at N+5, hit_cnt=3; len=0 -> eight SHIFT cycles, hit_cnt=8.
REQ-033 CW=2, len=8, z tied 1 -> hit_cnt saturates and reads 3 at done.
REQ-034 rd pulsed low after the 3rd SHIFT bit -> all outputs 0 immediately, no done pulse; new start then runs the full length.
REQ-035 start held high throughout a run -> no restart during LOAD/SHIFT/DONE; next run starts at the IDLE edge after done, with det_clr=1 one cycle later.
